// File: rtl/arm_multicycle_fsm.sv
// Main control FSM for the multicycle ARM datapath: fetch/decode/memory/execute/writeback.
// Optional macro ARM_FSM_BLINK_EN adds the BLINK state (state 10) for branch-with-link.
module arm_multicycle_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ALUOp,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               PCS,
    output logic               BL,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_BLINK    = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_irwrite;
    logic w_nextpc;
    logic w_regw;
    logic w_memw;
    logic w_pcs;
    logic w_rd_pc;
    logic w_unused_funct;

    assign w_rd_pc        = (Rd == 4'd15);
    assign w_unused_funct = &{1'b0, Funct[4:1]};

`ifdef ARM_FSM_BLINK_EN
    logic w_bl;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = S_FETCH;
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_pcs     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        ResultSrc = 2'b00;
`ifdef ARM_FSM_BLINK_EN
        w_bl      = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = MemReady;
                w_nextpc  = MemReady;
                w_next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
`ifdef ARM_FSM_BLINK_EN
                    2'b10:   w_next = Funct[4] ? S_BLINK : S_BRANCH;
`else
                    2'b10:   w_next = S_BRANCH;
`endif
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
                w_pcs     = w_rd_pc;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
                w_next = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUOp  = 1'b1;
                w_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw = 1'b1;
                w_pcs  = w_rd_pc;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcs     = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef ARM_FSM_BLINK_EN
            S_BLINK: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                w_regw    = 1'b1;
                w_bl      = 1'b1;
                w_next    = S_BRANCH;
            end
`endif
            default: begin
                // Unused encodings look like FETCH but never strobe.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_next    = S_FETCH;
            end
        endcase
    end

    // Strobes are killed combinationally while reset is held, aborting a pending store.
    assign IRWrite = w_irwrite & reset;
    assign NextPC  = w_nextpc  & reset;
    assign RegW    = w_regw    & reset;
    assign MemW    = w_memw    & reset;
    assign PCS     = w_pcs     & reset;
`ifdef ARM_FSM_BLINK_EN
    assign BL      = w_bl      & reset;
`else
    assign BL      = 1'b0;
`endif

    assign State = r_state;

endmodule

// File: tb/tb_arm_multicycle_fsm.sv
// Scoreboard bench for arm_multicycle_fsm: stimulus pushes per-cycle expectations, monitor checks at negedge.
module tb_arm_multicycle_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, PCS, BL;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] strb;   // {IRWrite,NextPC,RegW,MemW,PCS,BL}
        logic [6:0] mux;    // {AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    // Hand-written mux vectors per state
    localparam logic [6:0] M_FETCH = 7'b0_1_10_0_10;
    localparam logic [6:0] M_MADR  = 7'b0_0_01_0_00;
    localparam logic [6:0] M_MRD   = 7'b1_0_00_0_00;
    localparam logic [6:0] M_MWB   = 7'b0_0_00_0_01;
    localparam logic [6:0] M_EXR   = 7'b0_0_00_1_00;
    localparam logic [6:0] M_EXI   = 7'b0_0_01_1_00;
    localparam logic [6:0] M_AWB   = 7'b0_0_00_0_00;
    localparam logic [6:0] M_BR    = 7'b0_0_01_0_10;
    localparam logic [6:0] M_BLK   = 7'b0_1_11_0_10;

    arm_multicycle_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .PCS(PCS), .BL(BL), .State(State)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] rd, input logic mr,
                        input logic [3:0] st, input logic [5:0] strb, input logic [6:0] mux);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; Op = op; Funct = fn; Rd = rd; MemReady = mr;
        e.st = st; e.strb = strb; e.mux = mux;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [5:0] a_strb;
            logic [6:0] a_mux;
            e      = sb.pop_front();
            a_strb = {IRWrite, NextPC, RegW, MemW, PCS, BL};
            a_mux  = {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
            n_checks++;
            if (State !== e.st) begin
                n_fail++;
                $display("FAIL state t=%0t actual=%0d required=%0d", $time, State, e.st);
            end
            n_checks++;
            if (a_strb !== e.strb) begin
                n_fail++;
                $display("FAIL strobes t=%0t state=%0d actual=%b required=%b", $time, State, a_strb, e.strb);
            end
            n_checks++;
            if (a_mux !== e.mux) begin
                n_fail++;
                $display("FAIL muxsel t=%0t state=%0d actual=%b required=%b", $time, State, a_mux, e.mux);
            end
        end
    end

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MemReady = 1'b1;
        // Reset held two cycles: strobes forced low even with MemReady=1
        step(0, 2'b00, 6'b000000, 4'd0, 1, 4'd0, 6'b000000, M_FETCH);
        step(0, 2'b00, 6'b000000, 4'd0, 1, 4'd0, 6'b000000, M_FETCH);
        // ADD reg, Rd=3: 0,1,6,8,0
        step(1, 2'b00, 6'b001000, 4'd3, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b00, 6'b001000, 4'd3, 1, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b00, 6'b001000, 4'd3, 1, 4'd6, 6'b000000, M_EXR);
        step(1, 2'b00, 6'b001000, 4'd3, 1, 4'd8, 6'b001000, M_AWB);
        // LDR Rd=15 with three stall cycles in MEMREAD
        step(1, 2'b01, 6'b011001, 4'd15, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b01, 6'b011001, 4'd15, 0, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b01, 6'b011001, 4'd15, 0, 4'd2, 6'b000000, M_MADR);
        step(1, 2'b01, 6'b011001, 4'd15, 0, 4'd3, 6'b000000, M_MRD);
        step(1, 2'b01, 6'b011001, 4'd15, 0, 4'd3, 6'b000000, M_MRD);
        step(1, 2'b01, 6'b011001, 4'd15, 0, 4'd3, 6'b000000, M_MRD);
        step(1, 2'b01, 6'b011001, 4'd15, 1, 4'd3, 6'b000000, M_MRD);
        step(1, 2'b01, 6'b011001, 4'd15, 1, 4'd4, 6'b001010, M_MWB);
        // STR with two stall cycles: MemW for exactly three cycles
        step(1, 2'b01, 6'b011000, 4'd2, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b01, 6'b011000, 4'd2, 1, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b01, 6'b011000, 4'd2, 0, 4'd2, 6'b000000, M_MADR);
        step(1, 2'b01, 6'b011000, 4'd2, 0, 4'd5, 6'b000100, M_MRD);
        step(1, 2'b01, 6'b011000, 4'd2, 0, 4'd5, 6'b000100, M_MRD);
        step(1, 2'b01, 6'b011000, 4'd2, 1, 4'd5, 6'b000100, M_MRD);
        // B: 0,1,9,0
        step(1, 2'b10, 6'b101000, 4'd0, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b10, 6'b101000, 4'd0, 1, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b10, 6'b101000, 4'd0, 1, 4'd9, 6'b000010, M_BR);
        // BL: link state only when the feature is built in
        step(1, 2'b10, 6'b110000, 4'd0, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b10, 6'b110000, 4'd0, 1, 4'd1, 6'b000000, M_FETCH);
`ifdef ARM_FSM_BLINK_EN
        step(1, 2'b10, 6'b110000, 4'd0, 1, 4'd10, 6'b001001, M_BLK);
`endif
        step(1, 2'b10, 6'b110000, 4'd0, 1, 4'd9, 6'b000010, M_BR);
        // Undefined Op=11: 0,1,0
        step(1, 2'b11, 6'b000000, 4'd0, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b11, 6'b000000, 4'd0, 1, 4'd1, 6'b000000, M_FETCH);
        // Data-processing immediate, Rd=15: 0,1,7,8 with PCS
        step(1, 2'b00, 6'b101000, 4'd15, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b00, 6'b101000, 4'd15, 1, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b00, 6'b101000, 4'd15, 1, 4'd7, 6'b000000, M_EXI);
        step(1, 2'b00, 6'b101000, 4'd15, 1, 4'd8, 6'b001010, M_AWB);
        // STR aborted by reset in MEMWRITE
        step(1, 2'b01, 6'b011000, 4'd1, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b01, 6'b011000, 4'd1, 0, 4'd1, 6'b000000, M_FETCH);
        step(1, 2'b01, 6'b011000, 4'd1, 0, 4'd2, 6'b000000, M_MADR);
        step(1, 2'b01, 6'b011000, 4'd1, 0, 4'd5, 6'b000100, M_MRD);
        step(0, 2'b01, 6'b011000, 4'd1, 0, 4'd5, 6'b000000, M_MRD);
        // Fetch stall after reset release, then proceed to DECODE
        step(1, 2'b00, 6'b000000, 4'd0, 0, 4'd0, 6'b000000, M_FETCH);
        step(1, 2'b00, 6'b000000, 4'd0, 1, 4'd0, 6'b110000, M_FETCH);
        step(1, 2'b00, 6'b000000, 4'd0, 1, 4'd1, 6'b000000, M_FETCH);
        stim_done = 1'b1;
    end

    initial begin
        fork
            begin
                wait (stim_done && sb.size() == 0);
                @(posedge clk);
            end
            begin
                #20000;
                n_checks++;
                n_fail++;
                $display("FAIL timeout pending=%0d required=0", sb.size());
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_fsm.md
Name: arm_multicycle_fsm

Overview:
Main control state machine for the multicycle ARM datapath. It sequences fetch, decode, memory, execute and writeback over several cycles, and stalls on a memory-ready handshake. The conditional-logic block consumes its RegW/MemW/NextPC/PCS strobes and gates them by the condition check. The instruction decoder supplies Op/Funct/Rd from the latched instruction register.

Parameters:
STATE_W, 4, width of the state register and of the State debug port (fixed at 4; not intended to change).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
MemReady  in  1  memory completes the current access this cycle
IRWrite  out  1  latch instruction register
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
ALUSrcA  out  1  0 = RegA, 1 = PC
ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4, 11 = constant 0
ALUOp  out  1  1 = ALU decoder uses Funct; 0 = add
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
NextPC  out  1  PC write enable (fetch increment)
RegW  out  1  register write strobe (pre-condition)
MemW  out  1  memory write strobe (pre-condition)
PCS  out  1  PC write from Result (branch, or write to R15)
BL  out  1  link write to R14 (0 unless BLINK_EN)
State  out  4  current state, for debug and verification

Behaviour:
- Moore FSM with one registered state. Outputs are combinational from state, with the MemReady gating noted per state. Unlisted outputs in a state are 0.
- Reset: when reset is 0 at a clk edge, the next state is FETCH (0).
  - While reset is 0, IRWrite, NextPC, RegW, MemW, PCS and BL are forced to 0 combinationally, in any state.
  - A reset during MEMWRITE aborts the store; MemW drops in the same cycle reset goes low.
- State encodings and outputs:
  - FETCH=0: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE=1: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 available as R15). Next state:
    - Op=01 -> MEMADR
    - Op=00 with Funct[5]=0 -> EXECR
    - Op=00 with Funct[5]=1 -> EXECI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (treated as a NOP; no strobes)
  - MEMADR=2: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD=3: AdrSrc=1. Waits for MemReady=1, then goes to MEMWB.
  - MEMWB=4: ResultSrc=01, RegW=1, PCS=(Rd==15). Next state FETCH.
  - MEMWRITE=5: AdrSrc=1, MemW=1, held every cycle until MemReady=1, then FETCH. MemW stays asserted exactly (stall cycles + 1).
  - EXECR=6: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next state ALUWB.
  - EXECI=7: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next state ALUWB.
  - ALUWB=8: ResultSrc=00, RegW=1, PCS=(Rd==15). Next state FETCH.
  - BRANCH=9: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCS=1. Next state FETCH.
  - Encodings 10..15: next state FETCH; outputs as FETCH with strobes forced to 0.
- Instruction latencies with MemReady always 1:
  - data-processing: 4 cycles
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
  - undefined Op=11: 2 cycles
- MemReady is sampled only in FETCH, MEMREAD and MEMWRITE and is ignored elsewhere.

Optional Feature:
Macro ARM_FSM_BLINK_EN.
- Defined:
  - DECODE with Op=10 and Funct[4]=1 goes to BLINK=10.
  - BLINK outputs: ALUSrcA=1, ALUSrcB=11, ResultSrc=10 (PC, already +4), RegW=1, BL=1. Next state BRANCH.
  - BL takes 4 cycles.
- Not defined:
  - Funct[4] is ignored; BL executes as B.
  - BL is tied to 0, and state 10 is unreachable.

Test Plan:
- reset=0 for 2 cycles, then 1; MemReady=1 -> State=0 and IRWrite=NextPC=1. Check that RegW, MemW and PCS stay 0 throughout reset.
- ADD reg (Op=00, Funct=001000, Rd=3), MemReady=1 -> State sequence 0,1,6,8,0. RegW=1 only in state 8; PCS=0.
- LDR (Op=01, Funct=011001, Rd=15), MemReady low 3 cycles in MEMREAD -> State sequence 0,1,2,3,3,3,3,4,0. In state 4, RegW=1 and PCS=1.
- STR (Op=01, Funct=011000), MemReady low 2 cycles -> MemW=1 for exactly 3 cycles in state 5, AdrSrc=1, then State=0.
- B (Op=10, Funct=101000) -> State sequence 0,1,9,0, with PCS=1 and ALUSrcB=01 in state 9. With ARM_FSM_BLINK_EN and Funct=110000 -> 0,1,10,9,0 with BL=RegW=1 in state 10.
- Reset driven low during MEMWRITE with MemReady=0 -> MemW=0 in the same cycle; State=0 after the next edge.
